log2_early_div8: RTL
====================

Name: log2_early_div8

Overview:
- Iterative unsigned 8-bit divider in the ALU datapath, directly downstream of the floor-log2 unit.
- Takes the dividend's floor-log2 (the flog2 y_o output) alongside the operands and starts the restoring-division loop at that bit position, skipping leading-zero iterations.
- Latency is data-dependent: msb+1 iterations.
- Valid/ready handshake on both sides; one division in flight at a time.

Parameters:
WIDTH, 8, operand/result width; fixed at 8 to match the log2 unit; other values unsupported.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-high reset
valid_i  input  1  operands valid
ready_o  output  1  block can accept operands
dividend_i  input  8  unsigned dividend
divisor_i  input  8  unsigned divisor
msb_i  input  8  floor-log2 of dividend from the log2 unit; only [2:0] used, [7:3] ignored
valid_o  output  1  result valid
ready_i  input  1  downstream accepts result
quotient_o  output  8  unsigned quotient
remainder_o  output  8  unsigned remainder
div_by_zero_o  output  1  divisor was zero; qualified by valid_o

Behaviour:
- Reset: async assert forces state IDLE, valid_o=0, quotient_o=0, remainder_o=0, div_by_zero_o=0, all internal registers 0. ready_o=1 (it is state==IDLE). Reset mid-RUN or mid-DONE aborts; the result is lost.
- Handshake: input accepted on a rising edge with valid_i && ready_o. ready_o is high only in IDLE. Result transfers on a rising edge with valid_o && ready_i. Operands are captured at accept; later input changes have no effect.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on accept with divisor_i != 0. Capture dividend_i, divisor_i and k = msb_i[2:0]. Clear R (9-bit partial remainder) and Q (8-bit quotient).
- IDLE -> DONE on accept with divisor_i == 0. Next cycle: quotient_o=8'hFF, remainder_o=dividend_i masked (below), div_by_zero_o=1, valid_o=1.
- Masking: only dividend bits [k:0] participate; bits above k are treated as 0. Caller guarantees consistency; block does not check it.
- RUN, each cycle:
  - P = {R[7:0], D[k]}.
  - If P >= divisor: R <= P - divisor, Q[k] <= 1; else R <= P, Q[k] <= 0.
  - Q bits above the starting k remain 0.
  - If k == 0: go DONE, load quotient_o/remainder_o from the final Q/R, div_by_zero_o=0, valid_o=1. Else k <= k-1.
- RUN duration is exactly msb_i[2:0]+1 cycles. For accept at edge N, valid_o rises after edge N+msb+1.
- DONE: outputs held stable while valid_o && !ready_i. On handshake: -> IDLE, valid_o=0. quotient_o/remainder_o/div_by_zero_o keep their last values until the next result loads.
- Throughput: one division per (msb+1)+2 cycles minimum. No accept is possible in the same cycle as a result transfer, because ready_o depends only on state.
- Widths: R is 9 bits internally so that P < 2*divisor <= 510; the final remainder always fits in 8 bits (< divisor).
- Dividend 0 or 1 with msb_i=0: one iteration; yields q=0,r=0 or q=1 (divisor 1) / q=0,r=1 (divisor >1).

Test Plan:
- dividend=200, divisor=7, msb=7, ready_i=1 -> valid_o exactly 8 cycles after accept; q=28, r=4, dbz=0; ready_o low through RUN/DONE.
- dividend=1, divisor=1, msb=0 -> valid_o 1 cycle after accept, q=1, r=0. Then dividend=0, divisor=5, msb=0 -> q=0, r=0, 1 cycle.
- dividend=37, divisor=0, msb=5 -> valid_o 1 cycle after accept, q=8'hFF, r=37, dbz=1. Next division 12/3 (msb=3) -> dbz=0, q=4, r=0.
- Backpressure: 255/16, msb=7, ready_i low for 3 cycles after valid_o -> q=15, r=15 held stable all 3 cycles; transfer on the 4th; ready_o returns high the cycle after.
- Reset: assert rst_i asynchronously mid-RUN (iteration 3 of 200/7) -> outputs zero and ready_o=1 immediately, without waiting for a clock edge. Next division 100/9, msb=6 -> q=11, r=1, latency 7.
- Masking: dividend=8'hF5, divisor=3, msb=3 -> only low nibble 5 used; q=1, r=2.
- Random: 2000 random operand pairs with msb_i from a reference log2 -> q/r match the golden model, and latency always equals msb+1.

Source files
------------

// File: rtl/log2_early_div8.sv
// Iterative unsigned 8-bit restoring divider that starts at the dividend's
// floor-log2 bit position, so it skips the leading-zero iterations.
// Ports:
//   clk_i, rst_i (async, active high)
//   valid_i/ready_o                      operand handshake
//   dividend_i, divisor_i, msb_i         operands; msb_i[2:0] is the start bit
//   valid_o/ready_i                      result handshake
//   quotient_o, remainder_o, div_by_zero_o  result, held until the next load
module log2_early_div8 #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic [7:0]       msb_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_by_zero_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] dv;
   logic [2:0]       k;
   logic [WIDTH:0]   r;
   logic [WIDTH-1:0] q;

   logic [WIDTH:0]   p;
   logic             ge;
   logic [WIDTH:0]   r_nx;
   logic [WIDTH-1:0] q_nx;
   logic [WIDTH-1:0] mask;

   // r[8] is never read back: the remainder is always below the divisor,
   // so only the shifted-out position of P needs the ninth bit.
   logic unused;
   assign unused = ^{msb_i[7:3], r[WIDTH]};

   assign ready_o = (state == IDLE);

   always_comb begin
      p    = {r[WIDTH-1:0], d[k]};
      ge   = (p >= {1'b0, dv});
      r_nx = ge ? (p - {1'b0, dv}) : p;
      q_nx = q;
      q_nx[k] = ge;
      // Keep only dividend bits [msb:0] for the divide-by-zero remainder.
      mask = 8'hFF >> (3'd7 - msb_i[2:0]);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= IDLE;
         d             <= '0;
         dv            <= '0;
         k             <= '0;
         r             <= '0;
         q             <= '0;
         valid_o       <= 1'b0;
         quotient_o    <= '0;
         remainder_o   <= '0;
         div_by_zero_o <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (valid_i) begin
                  if (divisor_i == '0) begin
                     state         <= DONE;
                     quotient_o    <= 8'hFF;
                     remainder_o   <= dividend_i & mask;
                     div_by_zero_o <= 1'b1;
                     valid_o       <= 1'b1;
                  end else begin
                     state <= RUN;
                     d     <= dividend_i;
                     dv    <= divisor_i;
                     k     <= msb_i[2:0];
                     r     <= '0;
                     q     <= '0;
                  end
               end
            end
            RUN: begin
               r <= r_nx;
               q <= q_nx;
               if (k == 3'd0) begin
                  state         <= DONE;
                  quotient_o    <= q_nx;
                  remainder_o   <= r_nx[WIDTH-1:0];
                  div_by_zero_o <= 1'b0;
                  valid_o       <= 1'b1;
               end else begin
                  k <= k - 3'd1;
               end
            end
            DONE: begin
               if (ready_i) begin
                  state   <= IDLE;
                  valid_o <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
